// File: rtl/leaf_refill_scheduler_pkg.sv
// Shared types and constants for the leaf refill scheduler.
//   state_e    : scheduler FSM states
//   CmdBeatsW  : width of the burst-length field sent to the data mover
package leaf_refill_scheduler_pkg;

   localparam int unsigned CmdBeatsW = 16;

   typedef enum logic [1:0] {
      StIdle,
      StArb,
      StCmd,
      StStream
   } state_e;

endpackage

// File: rtl/leaf_refill_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first asserted request at or after ptr_i, wrapping modulo N.
//   req_i   : per-leaf request vector
//   ptr_i   : index with highest priority this decision
//   gnt_o   : one-hot grant (all zero when no request)
//   idx_o   : index of the granted request
//   valid_o : at least one request present
module leaf_refill_scheduler_rr_arbiter
   import leaf_refill_scheduler_pkg::*;
#(
   parameter int unsigned N = 16,
   localparam int unsigned LW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [LW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [LW-1:0] idx_o,
   output logic          valid_o
);

   logic [LW-1:0] cand;
   logic          found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      // N is a power of two, so the LW-bit add wraps naturally.
      for (int unsigned k = 0; k < N; k++) begin
         cand = ptr_i + LW'(k);
         if (!found && req_i[cand]) begin
            found = 1'b1;
            idx_o = cand;
         end
      end
      if (found) begin
         gnt_o[idx_o] = 1'b1;
      end
      valid_o = found;
   end

endmodule

// File: rtl/leaf_refill_scheduler.sv
// Shares one AXI-stream read channel among C_NUM_LEAVES leaf unpackers.
// Keeps a remaining-beat counter per leaf, round-robin picks a leaf that has
// work and FIFO room, issues one burst command, then steers the returned beats
// to that leaf. The final beat of a leaf's whole run is flagged with tlast.
// Ports:
//   s_axis_aclk / s_axis_areset : clock, synchronous active-high reset
//   cfg_*        : load run length (beats) for one leaf
//   leaf_room    : per-leaf "can absorb a full burst"
//   cmd_*        : burst command to the data mover
//   s_axis_*     : beats from the data mover
//   m_axis_*     : beats to the leaves (tvalid one-hot, data/tlast shared)
//   all_done     : idle with every remaining counter zero
//   err_burst    : sticky, mover tlast disagreed with the beat counter
module leaf_refill_scheduler
   import leaf_refill_scheduler_pkg::*;
#(
   parameter int unsigned C_NUM_LEAVES       = 16,
   parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
   parameter int unsigned C_BURST_BEATS      = 16,
   parameter int unsigned C_RUN_WIDTH        = 32,
   localparam int unsigned LW = $clog2(C_NUM_LEAVES)
) (
   input  logic                          s_axis_aclk,
   input  logic                          s_axis_areset,
   input  logic                          cfg_valid,
   output logic                          cfg_ready,
   input  logic [LW-1:0]                 cfg_leaf,
   input  logic [C_RUN_WIDTH-1:0]        cfg_beats,
   input  logic [C_NUM_LEAVES-1:0]       leaf_room,
   output logic                          cmd_valid,
   input  logic                          cmd_ready,
   output logic [LW-1:0]                 cmd_leaf,
   output logic [CmdBeatsW-1:0]          cmd_beats,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                          s_axis_tlast,
   output logic [C_NUM_LEAVES-1:0]       m_axis_tvalid,
   input  logic [C_NUM_LEAVES-1:0]       m_axis_tready,
   output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                          m_axis_tlast,
   output logic                          all_done,
   output logic                          err_burst
);

   localparam logic [C_RUN_WIDTH-1:0] BurstRun = C_RUN_WIDTH'(C_BURST_BEATS);
   localparam logic [CmdBeatsW-1:0]   BurstCmd = CmdBeatsW'(C_BURST_BEATS);

   state_e                  state_q, state_d;
   logic [LW-1:0]           rr_ptr_q, rr_ptr_d;
   logic [LW-1:0]           sel_q, sel_d;
   logic [C_NUM_LEAVES-1:0] sel_oh_q, sel_oh_d;
   logic [CmdBeatsW-1:0]    len_q, len_d;
   logic [CmdBeatsW-1:0]    beat_cnt_q, beat_cnt_d;
   logic                    err_q, err_d;
   logic [C_RUN_WIDTH-1:0]  remaining_q [C_NUM_LEAVES];
   logic [C_RUN_WIDTH-1:0]  remaining_d [C_NUM_LEAVES];

   logic [C_NUM_LEAVES-1:0] eligible;
   logic                    any_remaining;
   logic [C_NUM_LEAVES-1:0] arb_gnt;
   logic [LW-1:0]           arb_idx;
   logic                    arb_valid;
   logic [C_RUN_WIDTH-1:0]  arb_rem;
   logic                    streaming;
   logic                    last_beat;
   logic                    beat_hs;

   // Work-and-room per leaf; also the idle summary for all_done.
   always_comb begin
      eligible      = '0;
      any_remaining = 1'b0;
      for (int unsigned i = 0; i < C_NUM_LEAVES; i++) begin
         eligible[i]   = leaf_room[i] & (remaining_q[i] != '0);
         any_remaining = any_remaining | (remaining_q[i] != '0);
      end
   end

   leaf_refill_scheduler_rr_arbiter #(
      .N (C_NUM_LEAVES)
   ) u_arb (
      .req_i   (eligible),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   assign arb_rem   = remaining_q[arb_idx];
   assign streaming = (state_q == StStream);
   assign last_beat = (beat_cnt_q == len_q - CmdBeatsW'(1));

   // Zero-latency pass-through to the selected leaf only.
   assign m_axis_tvalid = streaming ? (sel_oh_q & {C_NUM_LEAVES{s_axis_tvalid}}) : '0;
   assign s_axis_tready = streaming & |(sel_oh_q & m_axis_tready);
   assign m_axis_tdata  = s_axis_tdata;
   // Run end only when this burst drains the leaf's remaining count.
   assign m_axis_tlast  = streaming & last_beat &
                          (remaining_q[sel_q] == C_RUN_WIDTH'(len_q));
   assign beat_hs       = streaming & s_axis_tvalid & s_axis_tready;

   // Block cfg writes to the leaf being served so its counter stays coherent.
   assign cfg_ready = (state_q == StIdle) | (cfg_leaf != sel_q);
   assign cmd_leaf  = sel_q;
   assign cmd_beats = len_q;
   assign all_done  = (state_q == StIdle) & ~any_remaining;
   assign err_burst = err_q;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      sel_d       = sel_q;
      sel_oh_d    = sel_oh_q;
      len_d       = len_q;
      beat_cnt_d  = beat_cnt_q;
      err_d       = err_q;
      remaining_d = remaining_q;
      cmd_valid   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (|eligible) begin
               state_d = StArb;
            end
         end
         StArb: begin
            // Room may have dropped since IDLE; fall back without a command.
            if (arb_valid) begin
               sel_d    = arb_idx;
               sel_oh_d = arb_gnt;
               len_d    = (arb_rem < BurstRun) ? CmdBeatsW'(arb_rem) : BurstCmd;
               state_d  = StCmd;
            end else begin
               state_d = StIdle;
            end
         end
         StCmd: begin
            cmd_valid = 1'b1;
            if (cmd_ready) begin
               rr_ptr_d   = sel_q + LW'(1);
               beat_cnt_d = '0;
               state_d    = StStream;
            end
         end
         StStream: begin
            if (beat_hs) begin
               beat_cnt_d = beat_cnt_q + CmdBeatsW'(1);
               // Our counter decides where the burst ends; mover tlast is only checked.
               if (s_axis_tlast != last_beat) begin
                  err_d = 1'b1;
               end
               if (last_beat) begin
                  remaining_d[sel_q] = remaining_q[sel_q] - C_RUN_WIDTH'(len_q);
                  state_d            = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (cfg_valid && cfg_ready) begin
         remaining_d[cfg_leaf] = cfg_beats;
      end
   end

   always_ff @(posedge s_axis_aclk) begin
      if (s_axis_areset) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         sel_q      <= '0;
         sel_oh_q   <= '0;
         len_q      <= '0;
         beat_cnt_q <= '0;
         err_q      <= 1'b0;
         for (int unsigned i = 0; i < C_NUM_LEAVES; i++) begin
            remaining_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         sel_q       <= sel_d;
         sel_oh_q    <= sel_oh_d;
         len_q       <= len_d;
         beat_cnt_q  <= beat_cnt_d;
         err_q       <= err_d;
         remaining_q <= remaining_d;
      end
   end

endmodule

// File: tb/tb_leaf_refill_scheduler.sv
// Scoreboard bench for leaf_refill_scheduler: a run-length model pushes the
// expected command lengths and per-beat tlast flags for each leaf; a monitor
// pops and compares whenever the DUT presents a command or a beat.
module tb_leaf_refill_scheduler;

   localparam int unsigned N  = 8;
   localparam int unsigned W  = 64;
   localparam int unsigned B  = 16;
   localparam int unsigned R  = 32;
   localparam int unsigned LW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [LW-1:0] cfg_leaf = '0;
   logic [R-1:0]  cfg_beats = '0;
   logic [N-1:0]  leaf_room = '0;
   logic          cmd_valid;
   logic          cmd_ready = 1'b0;
   logic [LW-1:0] cmd_leaf;
   logic [15:0]   cmd_beats;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic [W-1:0]  s_axis_tdata = '0;
   logic          s_axis_tlast = 1'b0;
   logic [N-1:0]  m_axis_tvalid;
   logic [N-1:0]  m_axis_tready = '0;
   logic [W-1:0]  m_axis_tdata;
   logic          m_axis_tlast;
   logic          all_done;
   logic          err_burst;

   always #5 clk = ~clk;

   leaf_refill_scheduler #(
      .C_NUM_LEAVES       (N),
      .C_AXIS_TDATA_WIDTH (W),
      .C_BURST_BEATS      (B),
      .C_RUN_WIDTH        (R)
   ) dut (
      .s_axis_aclk   (clk),
      .s_axis_areset (rst),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_leaf      (cfg_leaf),
      .cfg_beats     (cfg_beats),
      .leaf_room     (leaf_room),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_leaf      (cmd_leaf),
      .cmd_beats     (cmd_beats),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast),
      .all_done      (all_done),
      .err_burst     (err_burst)
   );

   int total = 0;
   int bad   = 0;

   // Scoreboard: expected burst lengths and per-beat tlast flags per leaf.
   int unsigned exp_cmd  [N][$];
   bit          exp_last [N][$];
   int          cmd_log  [$];

   // Stimulus knobs set by the main sequence.
   logic [N-1:0] room_mask = '1;
   bit           room_rand = 1'b0;
   bit           tog_mode  = 1'b0;
   int           err_at    = -1;

   // Mover / monitor hand-off.
   bit           mon_cmd_hs = 1'b0;
   bit           mon_beat_hs = 1'b0;
   int           mon_cmd_len = 0;
   int           mon_left = 0;
   int           cur_leaf = 0;
   bit           mv_active = 1'b0;
   int           mv_len = 0;
   int           mv_idx = 0;
   logic [W-1:0] mv_data = '0;
   int           cyc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // A run of n beats is served as min(n,B)-sized bursts; only its very last beat carries tlast.
   task automatic model_load(input int l, input int n);
      int left;
      int len;
      left = n;
      while (left > 0) begin
         len = (left < int'(B)) ? left : int'(B);
         exp_cmd[l].push_back(len);
         for (int k = 0; k < len; k++) begin
            exp_last[l].push_back((left == len) && (k == len - 1));
         end
         left = left - len;
      end
   endtask

   function automatic int pending();
      int s;
      s = 0;
      for (int i = 0; i < int'(N); i++) begin
         s = s + exp_cmd[i].size() + exp_last[i].size();
      end
      return s;
   endfunction

   // Data mover and leaf-side drivers; inputs change 1 time unit after the edge.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (rst) begin
         mv_active     = 1'b0;
         mv_idx        = 0;
         mv_len        = 0;
         s_axis_tvalid = 1'b0;
         s_axis_tlast  = 1'b0;
      end else begin
         if (mon_beat_hs) begin
            mv_idx++;
            if (mv_idx >= mv_len) mv_active = 1'b0;
            else mv_data = {$urandom, $urandom};
         end
         if (mon_cmd_hs) begin
            mv_active = 1'b1;
            mv_len    = mon_cmd_len;
            mv_idx    = 0;
            mv_data   = {$urandom, $urandom};
         end
         s_axis_tvalid = mv_active && ($urandom_range(0, 3) != 0);
         s_axis_tlast  = mv_active && ((mv_idx == mv_len - 1) != (mv_idx == err_at));
      end
      s_axis_tdata  = mv_data;
      cmd_ready     = ($urandom_range(0, 3) != 0);
      m_axis_tready = tog_mode ? (cyc[0] ? '1 : '0) : N'($urandom);
      leaf_room     = room_rand ? (room_mask & N'($urandom)) : room_mask;
   end

   // Monitor: pops the scoreboard on every command and beat handshake.
   always @(negedge clk) begin : mon
      int l;
      mon_cmd_hs  = 1'b0;
      mon_beat_hs = 1'b0;
      if (rst) begin
         mon_left = 0;
      end else if (cmd_valid && cmd_ready) begin
         l           = int'(cmd_leaf);
         mon_cmd_hs  = 1'b1;
         mon_cmd_len = int'(cmd_beats);
         mon_left    = int'(cmd_beats);
         cur_leaf    = l;
         cmd_log.push_back(l);
         chk("cmd_expected", exp_cmd[l].size() != 0, 1);
         if (exp_cmd[l].size() != 0) chk("cmd_beats", cmd_beats, exp_cmd[l].pop_front());
      end else if (mon_left > 0) begin
         chk("route_tvalid", m_axis_tvalid, s_axis_tvalid ? (64'd1 << cur_leaf) : 64'd0);
         chk("mirror_tready", s_axis_tready, m_axis_tready[cur_leaf]);
         if (s_axis_tvalid && s_axis_tready) begin
            mon_beat_hs = 1'b1;
            mon_left--;
            chk("beat_data", m_axis_tdata, mv_data);
            chk("beat_expected", exp_last[cur_leaf].size() != 0, 1);
            if (exp_last[cur_leaf].size() != 0) begin
               chk("beat_tlast", m_axis_tlast, exp_last[cur_leaf].pop_front());
            end
         end
      end else begin
         chk("idle_tready", s_axis_tready, 0);
      end
   end

   task automatic do_cfg(input int l, input int b);
      int n;
      n = 0;
      cfg_valid = 1'b1;
      cfg_leaf  = LW'(l);
      cfg_beats = R'(b);
      forever begin
         @(negedge clk);
         if (cfg_ready) break;
         n++;
         if (n > 300) break;
      end
      chk("cfg_accept", cfg_ready, 1);
      if (cfg_ready) model_load(l, b);
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (all_done && !mv_active && mon_left == 0) break;
         n++;
         if (n > 8000) break;
      end
      chk({"all_done_", name}, all_done, 1);
      chk({"sb_empty_", name}, pending(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      int n;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_err", err_burst, 0);
      chk("rst_all_done", all_done, 1);
      chk("rst_cfg_ready", cfg_ready, 1);
      @(posedge clk);
      #1;

      // Leaves 0,1,2 with one burst each come out in index order.
      cmd_log.delete();
      do_cfg(0, 16);
      do_cfg(1, 16);
      do_cfg(2, 16);
      wait_done("order");
      chk("order_cnt", cmd_log.size(), 3);
      chk("order_0", cmd_log[0], 0);
      chk("order_1", cmd_log[1], 1);
      chk("order_2", cmd_log[2], 2);

      // Pointer now sits at 3: with 1 and 4 both ready, 4 wins.
      cmd_log.delete();
      room_mask = '0;
      do_cfg(1, 5);
      do_cfg(4, 5);
      repeat (3) @(posedge clk);
      #1;
      room_mask = '1;
      wait_done("rrptr");
      chk("rrptr_first", cmd_log[0], 4);
      chk("rrptr_second", cmd_log[1], 1);

      // 40-beat run splits into 16,16,8; tlast only on beat 40.
      cmd_log.delete();
      do_cfg(3, 40);
      wait_done("split");
      chk("split_cnt", cmd_log.size(), 3);
      chk("split_leaf", cmd_log[2], 3);

      // Leaf 1 has no room for 100 cycles; leaf 2 goes first.
      cmd_log.delete();
      room_mask = 8'b1111_1101;
      do_cfg(1, 20);
      do_cfg(2, 8);
      repeat (100) @(posedge clk);
      #1;
      chk("room_first_cnt", cmd_log.size(), 1);
      chk("room_first_leaf", cmd_log[0], 2);
      room_mask = '1;
      wait_done("room");
      chk("room_then_leaf1", cmd_log[1], 1);

      // Leaf tready toggling every cycle mid-burst.
      tog_mode = 1'b1;
      do_cfg(7, 16);
      wait_done("toggle");
      tog_mode = 1'b0;

      // Randomized runs, random room and readiness.
      for (int p = 0; p < 12; p++) begin
         room_rand = 1'b1;
         start = $urandom_range(0, N - 1);
         for (int k = 0; k < int'(N); k++) begin
            if ($urandom_range(0, 2) != 0) do_cfg((start + k) % int'(N), $urandom_range(0, 40));
         end
         wait_done("rand");
      end
      room_rand = 1'b0;
      chk("err_clean", err_burst, 0);

      // Mover raises tlast on beat 5 of 16: sticky error, burst still runs 16 beats.
      err_at = 4;
      do_cfg(6, 16);
      wait_done("errburst");
      chk("err_set", err_burst, 1);
      err_at = -1;
      do_cfg(2, 3);
      wait_done("errsticky");
      chk("err_sticky", err_burst, 1);

      // Reset in the middle of a burst.
      do_cfg(5, 16);
      cfg_leaf = 3'd5;
      n = 0;
      forever begin
         @(negedge clk);
         if (mv_idx >= 7) break;
         n++;
         if (n > 500) break;
      end
      chk("reach_beat7", mv_idx >= 7, 1);
      chk("cfg_ready_busy", cfg_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_cmd_valid", cmd_valid, 0);
      chk("mid_rst_m_tvalid", m_axis_tvalid, 0);
      chk("mid_rst_s_tready", s_axis_tready, 0);
      chk("mid_rst_tlast", m_axis_tlast, 0);
      chk("mid_rst_err", err_burst, 0);
      chk("mid_rst_all_done", all_done, 1);
      chk("mid_rst_cfg_ready", cfg_ready, 1);
      for (int i = 0; i < int'(N); i++) begin
         exp_cmd[i].delete();
         exp_last[i].delete();
      end
      cmd_log.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      do_cfg(0, 3);
      wait_done("post_rst");
      chk("post_rst_leaf", cmd_log[0], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
